// File: rtl/se_arb_pkg.sv
// Shared types and default widths for the SE round-robin arbiter and the SE core.
package se_arb_pkg;

   typedef logic [0:0] port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   localparam int SE_INST_W = 8;
   localparam int SE_DATA_W = 128;

endpackage

// File: rtl/se_tag_fifo.sv
// Owner-tag FIFO: remembers which port issued each in-flight SE operation.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module se_tag_fifo
   import se_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  port_id_t                 push_tag_i,
   input  logic                     pop_i,
   output port_id_t                 head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   port_id_t      mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          push_ok;
   logic          pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Tag storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_tag_i;
      end
   end

endmodule

// File: rtl/se_rr_arbiter.sv
// Round-robin sharing of one in-order SE core between two requesters.
// Define SE_ARB_PERF_EN to add saturating issue/stall counters.
module se_rr_arbiter
   import se_arb_pkg::*;
#(
   parameter int DATA_W       = SE_DATA_W,
   parameter int INST_W       = SE_INST_W,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [INST_W-1:0]               req0_inst,
   input  logic [DATA_W-1:0]               req0_op1,
   input  logic [DATA_W-1:0]               req0_op2,
   input  logic [DATA_W-1:0]               req0_cond,
   input  logic                            req0_valid,
   output logic                            req0_ready,
   input  logic [INST_W-1:0]               req1_inst,
   input  logic [DATA_W-1:0]               req1_op1,
   input  logic [DATA_W-1:0]               req1_op2,
   input  logic [DATA_W-1:0]               req1_cond,
   input  logic                            req1_valid,
   output logic                            req1_ready,
   output logic [DATA_W-1:0]               rsp0_result,
   output logic                            rsp0_valid,
   input  logic                            rsp0_ready,
   output logic [DATA_W-1:0]               rsp1_result,
   output logic                            rsp1_valid,
   input  logic                            rsp1_ready,
   output logic [INST_W-1:0]               se_in_inst,
   output logic [DATA_W-1:0]               se_in_op1,
   output logic [DATA_W-1:0]               se_in_op2,
   output logic [DATA_W-1:0]               se_in_cond,
   output logic                            se_in_valid,
   input  logic                            se_in_ready,
   input  logic [DATA_W-1:0]               se_out_result,
   input  logic                            se_out_valid,
   output logic                            se_out_ready,
`ifdef SE_ARB_PERF_EN
   output logic [31:0]                     issue_cnt0,
   output logic [31:0]                     issue_cnt1,
   output logic [31:0]                     stall_cnt,
`endif
   output logic [$clog2(MAX_INFLIGHT):0]   inflight,
   output logic                            unexpected_rsp
);

   port_id_t   rr_ptr_q, rr_ptr_d;
   logic       unexp_q, unexp_d;
   port_id_t   grant;
   logic       gnt_valid;
   logic       can_issue;
   logic       issue_fire;
   logic       rsp_pop;
   port_id_t   tag_head;
   logic       tag_full;
   logic       tag_empty;

   se_tag_fifo #(
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_i     (issue_fire),
      .push_tag_i (grant),
      .pop_i      (rsp_pop),
      .head_o     (tag_head),
      .full_o     (tag_full),
      .empty_o    (tag_empty),
      .count_o    (inflight)
   );

   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = rr_ptr_q;
      end else if (req1_valid) begin
         grant = PORT1;
      end else begin
         grant = PORT0;
      end
   end

   always_comb begin
      if (grant == PORT1) begin
         gnt_valid  = req1_valid;
         se_in_inst = req1_inst;
         se_in_op1  = req1_op1;
         se_in_op2  = req1_op2;
         se_in_cond = req1_cond;
      end else begin
         gnt_valid  = req0_valid;
         se_in_inst = req0_inst;
         se_in_op1  = req0_op1;
         se_in_op2  = req0_op2;
         se_in_cond = req0_cond;
      end
   end

   // Full blocks issue even on a same-cycle pop, keeping rspN_ready off the issue path.
   assign can_issue   = se_in_ready & ~tag_full;
   assign se_in_valid = gnt_valid & ~tag_full;
   assign issue_fire  = se_in_valid & se_in_ready;
   assign req0_ready  = can_issue & req0_valid & (grant == PORT0);
   assign req1_ready  = can_issue & req1_valid & (grant == PORT1);

   assign rsp0_result  = se_out_result;
   assign rsp1_result  = se_out_result;
   assign rsp0_valid   = se_out_valid & ~tag_empty & (tag_head == PORT0);
   assign rsp1_valid   = se_out_valid & ~tag_empty & (tag_head == PORT1);
   assign se_out_ready = ~tag_empty & ((tag_head == PORT1) ? rsp1_ready : rsp0_ready);
   assign rsp_pop      = se_out_valid & se_out_ready;

   assign unexpected_rsp = unexp_q;

   always_comb begin
      rr_ptr_d = issue_fire ? ~grant : rr_ptr_q;
      unexp_d  = unexp_q | (se_out_valid & tag_empty);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q <= PORT0;
         unexp_q  <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         unexp_q  <= unexp_d;
      end
   end

`ifdef SE_ARB_PERF_EN
   logic [31:0] issue_cnt0_q, issue_cnt0_d;
   logic [31:0] issue_cnt1_q, issue_cnt1_d;
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic        stall;

   assign stall = (req0_valid | req1_valid) & ~issue_fire;

   always_comb begin
      issue_cnt0_d = issue_cnt0_q;
      issue_cnt1_d = issue_cnt1_q;
      stall_cnt_d  = stall_cnt_q;
      if (issue_fire && grant == PORT0 && issue_cnt0_q != '1) issue_cnt0_d = issue_cnt0_q + 32'd1;
      if (issue_fire && grant == PORT1 && issue_cnt1_q != '1) issue_cnt1_d = issue_cnt1_q + 32'd1;
      if (stall && stall_cnt_q != '1)                          stall_cnt_d  = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         issue_cnt0_q <= '0;
         issue_cnt1_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         issue_cnt0_q <= issue_cnt0_d;
         issue_cnt1_q <= issue_cnt1_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign issue_cnt0 = issue_cnt0_q;
   assign issue_cnt1 = issue_cnt1_q;
   assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_se_rr_arbiter.sv
// Self-checking bench for se_rr_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of ownership and round-robin priority.
module tb_se_rr_arbiter;

   localparam int DATA_W       = 128;
   localparam int INST_W       = 8;
   localparam int MAX_INFLIGHT = 4;

   logic              clock;
   logic              reset;
   logic [INST_W-1:0] req0_inst, req1_inst;
   logic [DATA_W-1:0] req0_op1, req0_op2, req0_cond;
   logic [DATA_W-1:0] req1_op1, req1_op2, req1_cond;
   logic              req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DATA_W-1:0] rsp0_result, rsp1_result;
   logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [INST_W-1:0] se_in_inst;
   logic [DATA_W-1:0] se_in_op1, se_in_op2, se_in_cond;
   logic              se_in_valid, se_in_ready;
   logic [DATA_W-1:0] se_out_result;
   logic              se_out_valid, se_out_ready;
   logic [2:0]        inflight;
   logic              unexpected_rsp;
`ifdef SE_ARB_PERF_EN
   logic [31:0]       issue_cnt0, issue_cnt1, stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   se_rr_arbiter #(.DATA_W(DATA_W), .INST_W(INST_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clock(clock), .reset(reset),
      .req0_inst(req0_inst), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_cond(req0_cond),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_inst(req1_inst), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_cond(req1_cond),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .rsp0_result(rsp0_result), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_result(rsp1_result), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .se_in_inst(se_in_inst), .se_in_op1(se_in_op1), .se_in_op2(se_in_op2),
      .se_in_cond(se_in_cond), .se_in_valid(se_in_valid), .se_in_ready(se_in_ready),
      .se_out_result(se_out_result), .se_out_valid(se_out_valid), .se_out_ready(se_out_ready),
`ifdef SE_ARB_PERF_EN
      .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1), .stall_cnt(stall_cnt),
`endif
      .inflight(inflight), .unexpected_rsp(unexpected_rsp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: owners of outstanding ops in issue order, and which port wins a tie next.
   int m_q[$];
   int m_prio;
   bit m_unexp;
   int m_issue0, m_issue1, m_stall;
   int m_grant, m_head;
   bit m_full, m_empty, m_fire, m_pop, m_se_valid, m_se_out_ready;
   bit m_rdy0, m_rdy1, m_rsp0_v, m_rsp1_v;

   task automatic model_comb();
      bit gv;
      m_full  = (m_q.size() == MAX_INFLIGHT);
      m_empty = (m_q.size() == 0);
      if (req0_valid && req1_valid) m_grant = m_prio;
      else                          m_grant = req1_valid ? 1 : 0;
      gv = (m_grant == 1) ? req1_valid : req0_valid;
      m_se_valid = gv && !m_full;
      m_fire     = m_se_valid && se_in_ready;
      m_rdy0     = m_fire && (m_grant == 0);
      m_rdy1     = m_fire && (m_grant == 1);
      m_head     = m_empty ? 0 : m_q[0];
      m_rsp0_v   = se_out_valid && !m_empty && (m_head == 0);
      m_rsp1_v   = se_out_valid && !m_empty && (m_head == 1);
      m_se_out_ready = !m_empty && ((m_head == 1) ? rsp1_ready : rsp0_ready);
      m_pop      = se_out_valid && m_se_out_ready;
   endtask

   task automatic advance();
      model_comb();
      @(posedge clock);
      if (reset) begin
         m_q.delete();
         m_prio = 0; m_unexp = 0;
         m_issue0 = 0; m_issue1 = 0; m_stall = 0;
      end else begin
         if (se_out_valid && m_empty) m_unexp = 1;
         if ((req0_valid || req1_valid) && !m_fire) m_stall++;
         if (m_pop) void'(m_q.pop_front());
         if (m_fire) begin
            m_q.push_back(m_grant);
            m_prio = 1 - m_grant;
            if (m_grant == 0) m_issue0++; else m_issue1++;
         end
      end
      #1;
   endtask

   task automatic set_idle();
      req0_valid = 0; req1_valid = 0;
      req0_inst = 8'h00; req1_inst = 8'h00;
      req0_op1 = '0; req0_op2 = '0; req0_cond = '0;
      req1_op1 = '0; req1_op2 = '0; req1_cond = '0;
      rsp0_ready = 0; rsp1_ready = 0;
      se_in_ready = 1; se_out_valid = 0; se_out_result = '0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1;
      advance();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (inflight !== 3'd0 || unexpected_rsp !== 1'b0) begin
         n_errors++; $display("FAIL reset_state: inflight=%0d unexp=%0b want 0 0", inflight, unexpected_rsp);
      end
      n_checks++;
      if ({req0_ready, req1_ready, se_in_valid, rsp0_valid, rsp1_valid, se_out_ready} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_handshakes: got %b want 000000",
                  {req0_ready, req1_ready, se_in_valid, rsp0_valid, rsp1_valid, se_out_ready});
      end
   endtask

   task automatic test_single_port();
      bit saw_rsp1 = 0;
      logic [DATA_W-1:0] exp_res;
      do_reset();
      req0_valid = 1; req0_inst = 8'h01;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (req0_ready !== 1'b1 || se_in_valid !== 1'b1 || se_in_inst !== 8'h01) begin
            n_errors++;
            $display("FAIL single_issue%0d: ready=%b valid=%b inst=%h want 1 1 01", i, req0_ready, se_in_valid, se_in_inst);
         end
         advance();
      end
      req0_valid = 0; rsp0_ready = 1; rsp1_ready = 1; se_out_valid = 1;
      for (int i = 0; i < 3; i++) begin
         exp_res = DATA_W'(10 + i);
         se_out_result = exp_res;
         #1;
         if (rsp1_valid) saw_rsp1 = 1;
         n_checks++;
         if (rsp0_valid !== 1'b1 || rsp0_result !== exp_res || se_out_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_rsp%0d: valid=%b result=%0h rdy=%b want 1 %0h 1", i, rsp0_valid, rsp0_result, se_out_ready, exp_res);
         end
         advance();
      end
      se_out_valid = 0;
      #1;
      n_checks++;
      if (saw_rsp1 || inflight !== 3'd0) begin
         n_errors++; $display("FAIL single_drain: rsp1_seen=%0b inflight=%0d want 0 0", saw_rsp1, inflight);
      end
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1; req1_valid = 1; req0_inst = 8'h10; req1_inst = 8'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (se_in_inst !== ((i % 2 == 0) ? 8'h10 : 8'h20) || req0_ready !== (i % 2 == 0) ||
             req1_ready !== (i % 2 == 1)) begin
            n_errors++;
            $display("FAIL contention_grant%0d: inst=%h r0=%b r1=%b want port %0d", i, se_in_inst, req0_ready, req1_ready, i % 2);
         end
         advance();
      end
      req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1; se_out_valid = 1;
      for (int i = 0; i < 4; i++) begin
         se_out_result = DATA_W'(32'h100 + i);
         #1;
         n_checks++;
         if (rsp0_valid !== (i % 2 == 0) || rsp1_valid !== (i % 2 == 1) ||
             ((i % 2 == 1) ? rsp1_result : rsp0_result) !== DATA_W'(32'h100 + i)) begin
            n_errors++;
            $display("FAIL contention_route%0d: v0=%b v1=%b want port %0d", i, rsp0_valid, rsp1_valid, i % 2);
         end
         advance();
      end
      se_out_valid = 0;
   endtask

   task automatic test_full();
      do_reset();
      req0_valid = 1; req0_inst = 8'h33;
      for (int i = 0; i < MAX_INFLIGHT; i++) advance();
      #1;
      n_checks++;
      if (req0_ready !== 1'b0 || se_in_valid !== 1'b0 || inflight !== 3'd4) begin
         n_errors++; $display("FAIL full_block: ready=%b valid=%b inflight=%0d want 0 0 4", req0_ready, se_in_valid, inflight);
      end
      se_out_valid = 1; rsp0_ready = 1; se_out_result = DATA_W'(32'h55);
      #1;
      n_checks++;
      if (se_out_ready !== 1'b1 || req0_ready !== 1'b0 || se_in_valid !== 1'b0) begin
         n_errors++; $display("FAIL full_pop_no_issue: oready=%b ready=%b valid=%b want 1 0 0", se_out_ready, req0_ready, se_in_valid);
      end
      advance();
      se_out_valid = 0;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1 || inflight !== 3'd3) begin
         n_errors++; $display("FAIL full_resume: ready=%b inflight=%0d want 1 3", req0_ready, inflight);
      end
      advance();
      req0_valid = 0; se_out_valid = 1;
      for (int i = 0; i < MAX_INFLIGHT; i++) advance();
      se_out_valid = 0;
      #1;
      n_checks++;
      if (inflight !== 3'd0) begin
         n_errors++; $display("FAIL full_drain: inflight=%0d want 0", inflight);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req1_valid = 1; advance();
      req1_valid = 0; req0_valid = 1; advance();
      req0_valid = 0;
      se_out_valid = 1; se_out_result = DATA_W'(32'hBEEF); rsp1_ready = 0; rsp0_ready = 1;
      #1;
      n_checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || se_out_ready !== 1'b0) begin
         n_errors++; $display("FAIL bp_hold: v1=%b v0=%b oready=%b want 1 0 0", rsp1_valid, rsp0_valid, se_out_ready);
      end
      advance(); advance();
      n_checks++;
      if (inflight !== 3'd2 || rsp1_result !== DATA_W'(32'hBEEF)) begin
         n_errors++; $display("FAIL bp_no_pop: inflight=%0d result=%0h want 2 beef", inflight, rsp1_result);
      end
      rsp1_ready = 1;
      #1;
      n_checks++;
      if (se_out_ready !== 1'b1) begin
         n_errors++; $display("FAIL bp_release: oready=%b want 1", se_out_ready);
      end
      advance();
      se_out_result = DATA_W'(32'hCAFE);
      #1;
      n_checks++;
      if (inflight !== 3'd1 || rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== DATA_W'(32'hCAFE)) begin
         n_errors++;
         $display("FAIL bp_next_head: inflight=%0d v0=%b v1=%b res=%0h want 1 1 0 cafe", inflight, rsp0_valid, rsp1_valid, rsp0_result);
      end
      advance();
      se_out_valid = 0;
   endtask

   task automatic test_error_reset();
      do_reset();
      se_out_valid = 1;
      #1;
      n_checks++;
      if (se_out_ready !== 1'b0 || unexpected_rsp !== 1'b0) begin
         n_errors++; $display("FAIL err_empty: oready=%b unexp=%b want 0 0", se_out_ready, unexpected_rsp);
      end
      advance();
      se_out_valid = 0;
      n_checks++;
      if (unexpected_rsp !== 1'b1) begin
         n_errors++; $display("FAIL err_set: unexp=%b want 1", unexpected_rsp);
      end
      advance(); advance();
      n_checks++;
      if (unexpected_rsp !== 1'b1) begin
         n_errors++; $display("FAIL err_sticky: unexp=%b want 1", unexpected_rsp);
      end
      req0_valid = 1; advance(); advance();
      req0_valid = 0;
      reset = 1; advance(); reset = 0;
      req0_valid = 1; req1_valid = 1;
      #1;
      n_checks++;
      if (inflight !== 3'd0 || unexpected_rsp !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL err_reset: inflight=%0d unexp=%b r0=%b r1=%b want 0 0 1 0", inflight, unexpected_rsp, req0_ready, req1_ready);
      end
      set_idle();
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         req0_valid = ($urandom_range(0, 99) < 60);
         req1_valid = ($urandom_range(0, 99) < 60);
         req0_inst = 8'($urandom); req1_inst = 8'($urandom);
         req0_op1 = {$urandom, $urandom, $urandom, $urandom};
         req1_op1 = {$urandom, $urandom, $urandom, $urandom};
         req0_op2 = {$urandom, $urandom, $urandom, $urandom};
         req1_op2 = {$urandom, $urandom, $urandom, $urandom};
         req0_cond = {$urandom, $urandom, $urandom, $urandom};
         req1_cond = {$urandom, $urandom, $urandom, $urandom};
         se_in_ready = ($urandom_range(0, 99) < 75);
         rsp0_ready = ($urandom_range(0, 99) < 70);
         rsp1_ready = ($urandom_range(0, 99) < 70);
         se_out_valid = (m_q.size() > 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 2);
         se_out_result = {$urandom, $urandom, $urandom, $urandom};
         #1;
         model_comb();
         n_checks++;
         if (req0_ready !== m_rdy0 || req1_ready !== m_rdy1 || se_in_valid !== m_se_valid ||
             rsp0_valid !== m_rsp0_v || rsp1_valid !== m_rsp1_v || se_out_ready !== m_se_out_ready ||
             inflight !== 3'(m_q.size()) || unexpected_rsp !== m_unexp) begin
            n_errors++;
            $display("FAIL random_ctrl cyc%0d: got r%b%b v%b rv%b%b or%b n%0d u%b want r%b%b v%b rv%b%b or%b n%0d u%b",
                     cyc, req0_ready, req1_ready, se_in_valid, rsp0_valid, rsp1_valid, se_out_ready, inflight,
                     unexpected_rsp, m_rdy0, m_rdy1, m_se_valid, m_rsp0_v, m_rsp1_v, m_se_out_ready,
                     m_q.size(), m_unexp);
         end
         if (m_se_valid) begin
            n_checks++;
            if (se_in_inst !== (m_grant ? req1_inst : req0_inst) || se_in_op1 !== (m_grant ? req1_op1 : req0_op1) ||
                se_in_op2 !== (m_grant ? req1_op2 : req0_op2) || se_in_cond !== (m_grant ? req1_cond : req0_cond)) begin
               n_errors++; $display("FAIL random_mux cyc%0d: inst=%h want port %0d", cyc, se_in_inst, m_grant);
            end
         end
         if (rsp0_valid !== rsp1_valid && (rsp0_result !== se_out_result || rsp1_result !== se_out_result)) bad++;
         advance();
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++; $display("FAIL random_result: mismatched result cycles=%0d want 0", bad);
      end
      set_idle();
   endtask

`ifdef SE_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 12; i++) begin
         req0_valid = (i < 5) || (i >= 8);
         req1_valid = (i >= 5) && (i < 8);
         se_in_ready = (i < 8);
         se_out_valid = (m_q.size() > 0);
         advance();
      end
      set_idle();
      rsp0_ready = 1; rsp1_ready = 1;
      se_out_valid = 1;
      advance(); advance();
      se_out_valid = 0;
      #1;
      n_checks++;
      if (issue_cnt0 !== 32'd5 || issue_cnt1 !== 32'd3 || stall_cnt !== 32'd4) begin
         n_errors++; $display("FAIL perf_counts: got %0d %0d %0d want 5 3 4", issue_cnt0, issue_cnt1, stall_cnt);
      end
      n_checks++;
      if (issue_cnt0 !== 32'(m_issue0) || issue_cnt1 !== 32'(m_issue1) || stall_cnt !== 32'(m_stall)) begin
         n_errors++; $display("FAIL perf_model: got %0d %0d %0d want %0d %0d %0d",
                              issue_cnt0, issue_cnt1, stall_cnt, m_issue0, m_issue1, m_stall);
      end
   endtask
`endif

   initial begin
      reset = 1;
      set_idle();
      m_prio = 0; m_unexp = 0;
      m_issue0 = 0; m_issue1 = 0; m_stall = 0;
      test_reset();
      test_single_port();
      test_contention();
      test_full();
      test_backpressure();
      test_error_reset();
      test_random();
`ifdef SE_ARB_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/se_rr_arbiter.md
Name: se_rr_arbiter

Overview:
- Shares one SE datapath instance between two independent requesters (port 0 and port 1). Arbitration is round-robin.
- Tracks the owner of each in-flight operation in a tag FIFO. Each SE result is routed back to the requester that issued it.
- Sits between two SE clients (e.g. two issue lanes) and a single SE core. It replaces duplicating the core when a self-composition check is not needed.
- The SE core returns results strictly in issue order. The arbiter relies on this.

Parameters:
- DATA_W, 128, width of op1/op2/cond/result.
- INST_W, 8, width of the instruction field.
- MAX_INFLIGHT, 4, tag FIFO depth; the maximum number of issued-but-unreturned operations. Must be a power of 2 and at least 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_inst  in  INST_W  requester N instruction (N = 0, 1).
- reqN_op1 / reqN_op2 / reqN_cond  in  DATA_W each  requester N operands.
- reqN_valid  in  1  requester N request valid.
- reqN_ready  out  1  requester N request accepted this cycle.
- rspN_result  out  DATA_W  result routed to requester N.
- rspN_valid  out  1  result for requester N is valid.
- rspN_ready  in  1  requester N accepts its result.
- se_in_inst / se_in_op1 / se_in_op2 / se_in_cond  out  INST_W / DATA_W  fields driven to the SE core.
- se_in_valid  out  1  issue to the SE core.
- se_in_ready  in  1  SE core can accept.
- se_out_result  in  DATA_W  SE core result.
- se_out_valid  in  1  SE core result valid.
- se_out_ready  out  1  arbiter accepts the SE result.
- inflight  out  clog2(MAX_INFLIGHT)+1  current tag FIFO occupancy.
- unexpected_rsp  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high):
  - rr_ptr <= 0, so port 0 has priority first.
  - Tag FIFO emptied: inflight = 0.
  - unexpected_rsp <= 0.
  - All ready/valid outputs are combinational and evaluate to 0 while the FIFO is empty and no request is present.
  - Reset mid-operation discards all outstanding tags. The SE core shares this reset, so nothing stale returns.
- Issue side (combinational grant, zero added latency):
  - can_issue = se_in_ready & !full.
  - When both requesters are valid, grant goes to rr_ptr. Otherwise grant goes to whichever requester is valid.
  - se_in_* is muxed from the granted port. se_in_valid = granted valid & !full.
  - reqN_ready = can_issue & (grant == N).
  - Issue fires when se_in_valid & se_in_ready. On a fire, N is pushed into the tag FIFO and rr_ptr <= ~N.
  - rr_ptr does not change when no issue fires. A requester waiting while the other is granted gets priority next.
- Full:
  - Issue is blocked while full, even if a pop occurs in the same cycle.
  - This avoids a combinational path from rspN_ready to se_in_valid.
- Return side:
  - head = FIFO head tag.
  - rspN_valid = se_out_valid & !empty & (head == N).
  - rspN_result = se_out_result, driven to both ports. Only the selected port's valid is asserted.
  - se_out_ready = !empty & rsp[head]_ready. The FIFO pops on se_out_valid & se_out_ready.
- Simultaneous push and pop (not full): occupancy stays unchanged; the pointers advance independently.
- Pointer wrap-around: read/write pointers are clog2(MAX_INFLIGHT)+1 bits. Full and empty are decoded via the MSB.
- se_out_valid while empty:
  - se_out_ready stays 0.
  - unexpected_rsp <= 1 and stays set until reset.
- The arbiter holds no data registers. The only state is rr_ptr, the tag FIFO, and the flags/counters.

Optional Feature:
- SE_ARB_PERF_EN defined: adds outputs issue_cnt0, issue_cnt1, stall_cnt (32 bits each).
  - issue_cntN increments on each issue from port N.
  - stall_cnt increments each cycle any reqN_valid is high and no issue fires.
  - All counters saturate at 2^32-1 and reset to 0.
- SE_ARB_PERF_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package se_arb_pkg:
  - port_id_t (1-bit tag type).
  - PORT0/PORT1 constants.
  - SE_INST_W = 8 and SE_DATA_W = 128 defaults, shared with the SE core.
- Sub-module se_tag_fifo:
  - Parameterised depth, 1-bit payload.
  - Ports: push, pop, head, full, empty, count.
  - Synchronous reset.
- Arbitration and routing stay in se_rr_arbiter.

Test Plan:
1. Single port: req0 issues inst=0x01 three times, SE returns 0xA, 0xB, 0xC → rsp0 receives 0xA, 0xB, 0xC in order; rsp1_valid never asserts; inflight returns to 0.
2. Contention: both valid every cycle with se_in_ready=1 → grants alternate 0,1,0,1 starting with port 0 after reset; results route to ports 0,1,0,1.
3. Full: MAX_INFLIGHT=4, SE withholds results → 4 issues then reqN_ready=0. Return one result with rsp ready in the same cycle req is valid → no issue that cycle; issue resumes the next cycle.
4. Backpressure: head tag=1, rsp1_ready=0 while SE result valid → se_out_ready=0 and the result holds. Raise rsp1_ready → pop occurs; rsp0 is unaffected.
5. Error/reset: se_out_valid=1 with empty FIFO → unexpected_rsp=1 next cycle and stays set. Assert reset with 2 in flight → inflight=0, rr_ptr=0, unexpected_rsp=0 after one edge.
6. With SE_ARB_PERF_EN: 5 issues from port 0, 3 from port 1, 4 stalled cycles → issue_cnt0=5, issue_cnt1=3, stall_cnt=4.
